// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers. Each channel toggles sclk every hp cycles;
// new half-periods and enable changes only take effect on phase boundaries.
module clk_div_bank #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int CH_W         = 2,
  parameter int DEFAULT_HALF = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active
);

  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HALF);

  logic [NUM_CH-1:0] pend_valid;

  // Channels outside the bank always accept and drop the write.
  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) cfg_ready = ~pend_valid[c];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : ch_g
    logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, hp_d, pend_q, pend_d;
    logic             pv_q, pv_d, sclk_q, sclk_d, tick_q, tick_d, act_q, act_d;
    logic             run, go, last, wr;

    assign run  = en[i] & (hp_q != '0);
    assign go   = act_q | run;
    // A zero half-period still lets a high phase finish on the next edge.
    assign last = go & ((hp_q == '0) ? sclk_q : (cnt_q == hp_q - CNT_W'(1)));
    assign wr   = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

    always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      tick_d = 1'b0;
      act_d  = act_q;
      hp_d   = hp_q;
      pend_d = pend_q;
      pv_d   = pv_q;

      if (!go) begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        act_d  = 1'b0;
      end else if (last) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        tick_d = ~sclk_q;
        act_d  = run | ~sclk_q;
      end else if (!run && !sclk_q) begin
        cnt_d = '0;
        act_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        act_d = 1'b1;
      end

      if (pv_q && (last || !go)) begin
        hp_d = pend_q;
        pv_d = 1'b0;
      end
      if (wr) begin
        pend_d = cfg_half;
        pv_d   = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        hp_q   <= HP_RST;
        pend_q <= '0;
        pv_q   <= 1'b0;
        sclk_q <= 1'b0;
        tick_q <= 1'b0;
        act_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        hp_q   <= hp_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
        sclk_q <= sclk_d;
        tick_q <= tick_d;
        act_q  <= act_d;
      end
    end

    assign sclk[i]       = sclk_q;
    assign tick[i]       = tick_q;
    assign active[i]     = act_q;
    assign pend_valid[i] = pv_q;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock divider generating `NUM_CH` independent divided clocks from a single system clock. Each channel has its own half-period register, enable and rising-edge tick strobe. Divisor changes and enable/disable take effect only at phase boundaries, so no output ever produces a runt pulse. It sits next to the system clock input and feeds slow strobes and clocks to peripheral blocks such as SPI and LED scanning.

## Interface
- `NUM_CH`, 4: number of divider channels (1..16).
- `CNT_W`, 32: width of the half-period and counter registers.
- `CH_W`, 2: width of the channel select; 2^CH_W >= NUM_CH.
- `DEFAULT_HALF`, 5000000: half-period loaded into every channel at reset; must be > 0.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  NUM_CH  per-channel run enable, level-sensitive.
- `cfg_valid`  in  1  configuration write request.
- `cfg_ready`  out  1  combinational; `~pend_valid[cfg_ch]`, or 1 if `cfg_ch >= NUM_CH`.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_half`  in  CNT_W  new half-period in clk cycles; 0 = halt channel.
- `sclk`  out  NUM_CH  divided clocks, registered.
- `tick`  out  NUM_CH  one-cycle pulse coincident with each 0->1 of `sclk[i]`.
- `active`  out  NUM_CH  registered; 1 while channel counting.

## Operation
- Per channel state: `cnt` (CNT_W), `hp` (CNT_W), `pend` (CNT_W), `pend_valid`, `sclk`, `active`.
- Reset: `cnt`=0, `hp`=DEFAULT_HALF, `pend_valid`=0, `sclk`=0, `tick`=0, `active`=0.
- RUN (`en[i]`=1, `hp`!=0): `cnt` increments each cycle; when `cnt`==`hp`-1: `cnt`<=0, `sclk` toggles. Period = 2*`hp` cycles, 50% duty. `hp`=1 gives clk/2.
- Graceful stop (`en[i]`=0 or `hp`==0): if `sclk`=1, continue counting to the next toggle, which takes `sclk` to 0; then idle. If `sclk`=0, idle immediately. Idle means `cnt` held at 0, `sclk`=0 and `active`=0.
- Restart from idle: `cnt` counts from 0; first rise after `hp` enabled cycles.
- Config transfer: `cfg_valid & cfg_ready`. It writes `pend[cfg_ch]` and sets `pend_valid`. Writes to `cfg_ch >= NUM_CH` are accepted and discarded.
- Pending apply: `hp`<=`pend` and `pend_valid`<=0 on the toggle edge (`cnt`==`hp`-1 while counting), or on any edge where the channel is idle. The new `hp` governs the next half-period only. It never truncates or extends the current one.
- Only one pending value per channel. A second write to that channel stalls (`cfg_ready`=0) until the first is applied.
- `cnt` comparisons are unsigned CNT_W-bit. `cnt` never exceeds `hp`-1, so there is no wrap-around beyond that.

## Timing
- Config accepted in cycle T: `pend_valid` is 1 from T+1. For an idle channel, `hp` is updated at the edge ending T+1. For a running channel, `hp` is updated at the first toggle edge after T. A transfer in the same cycle as a toggle applies at the following toggle.
- `tick[i]` is high in exactly the cycles where `sclk[i]` has just become 1. It is never asserted on 1->0 transitions.
- `active[i]` rises on the edge that starts counting and falls on the edge `sclk` returns to 0 during stop.
- `en` change and toggle in the same cycle: the toggle completes. Stop is then evaluated against the new `sclk` value.
- Reset mid-operation: all outputs are 0 and `hp`=DEFAULT_HALF at the next edge. Pending writes are lost.

## Test plan
All scenarios use NUM_CH=4, CNT_W=8, DEFAULT_HALF=3.
- Reset for 3 cycles, release, then `en`=4'b0001 -> `sclk[0]` rises 3 cycles after enable, period 6, `tick[0]` one pulse per 6 cycles. `sclk[3:1]`=0 and `active`=4'b0001.
- Write ch1 `cfg_half`=1 while idle, then `en`=4'b0010 -> `sclk[1]` toggles every cycle and `tick[1]` pulses every 2 cycles.
- Channel 0 running; write `cfg_half`=5 mid-high-phase -> current high lasts 3 cycles total, then every half lasts 5 cycles, with no pulse shorter than 3.
- Two back-to-back writes to ch2 while it runs at `hp`=3 -> `cfg_ready`=0 after the first is accepted until the next toggle, then the second is accepted.
- Drop `en[0]` one cycle into a high phase -> `sclk[0]` stays high 2 more cycles, falls, and remains 0. `active[0]` falls with it.
- Assert `reset` while all four channels run with a pending write -> next cycle `sclk`=`tick`=`active`=0. After release, periods are again 6 cycles.
